// File: rtl/lh_ootx_frame_decoder_if.sv
// Bundles the bit-stream inputs and the decoded word/status outputs of the OOTX frame decoder.
// The slave modport is the decoder; the master modport is the slicer/consumer side.
interface lh_ootx_frame_decoder_if #(
    parameter int ADDR_W = 8
);
    logic              DCLK;
    logic              DATA_IN;
    logic [15:0]       DATA_OUT;
    logic [ADDR_W-1:0] ADDRESS;
    logic              READY;
    logic [15:0]       LENGTH;
    logic              FRAME_DONE;
    logic              CRC_OK;
    logic              ERR_SYNC;
    logic              ERR_LEN;
    logic              ERR_TIMEOUT;
    logic              BUSY;

    modport master (
        output DCLK, DATA_IN,
        input  DATA_OUT, ADDRESS, READY, LENGTH, FRAME_DONE, CRC_OK,
        input  ERR_SYNC, ERR_LEN, ERR_TIMEOUT, BUSY
    );

    modport slave (
        input  DCLK, DATA_IN,
        output DATA_OUT, ADDRESS, READY, LENGTH, FRAME_DONE, CRC_OK,
        output ERR_SYNC, ERR_LEN, ERR_TIMEOUT, BUSY
    );
endinterface

// File: rtl/lh_ootx_frame_decoder.sv
// OOTX frame decoder: preamble hunt, length parse, payload word streaming and CRC32 trailer check
// for one lighthouse base-station bit stream. All outputs are registered, one CLK after the bit event.
module lh_ootx_frame_decoder #(
    parameter int MAX_PAYLOAD    = 64,
    parameter int ADDR_W         = 8,
    parameter int PREAMBLE_ZEROS = 17,
    parameter int CHECK_CRC      = 1,
    parameter int TIMEOUT_CYC    = 2**20
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    lh_ootx_frame_decoder_if.slave bus
);

    localparam int ZC_W = $clog2(PREAMBLE_ZEROS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LEN  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CRC  = 2'd3
    } state_t;

    // Reflected CRC32 update with one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    state_t            state_r, next_state_s;
    logic              dclk_meta_r, dclk_sync_r, dclk_prev_r;
    logic [ZC_W-1:0]   zero_cnt_r, zero_cnt_s;
    logic [4:0]        bit_cnt_r, bit_cnt_s;
    logic [15:0]       shift_r, shift_s;
    logic [15:0]       word_addr_r, word_addr_s;
    logic [31:0]       crc_r, crc_s;
    logic [15:0]       crc_lo_r, crc_lo_s;
    logic              crc_hi_sel_r, crc_hi_sel_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;

    logic [15:0]       data_out_r, data_out_s;
    logic [ADDR_W-1:0] address_r, address_s;
    logic              ready_r, ready_s;
    logic [15:0]       length_r, length_s;
    logic              frame_done_r, frame_done_s;
    logic              crc_ok_r, crc_ok_s;
    logic              err_sync_r, err_sync_s;
    logic              err_len_r, err_len_s;
    logic              err_timeout_r, err_timeout_s;
    logic              busy_r, busy_s;

    logic              bit_ev_s;
    logic [15:0]       full_s;
    logic [15:0]       last_word_s;
    logic [15:0]       end_word_s;
    logic [15:0]       byte_idx_s;

    assign bit_ev_s    = dclk_sync_r & ~dclk_prev_r;
    assign full_s      = {shift_r[14:0], bus.DATA_IN};
    // Bytes arrive MSB first and the first byte lands in the low half of the word.
    assign last_word_s = {shift_r[7:0], shift_r[15:8]};
    assign end_word_s  = {full_s[7:0], full_s[15:8]};
    assign byte_idx_s  = word_addr_r + ((bit_cnt_r == 5'd15) ? 16'd1 : 16'd0);

    // DCLK synchroniser and rise detector.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dclk_meta_r <= 1'b0;
            dclk_sync_r <= 1'b0;
            dclk_prev_r <= 1'b0;
        end else begin
            dclk_meta_r <= bus.DCLK;
            dclk_sync_r <= dclk_meta_r;
            dclk_prev_r <= dclk_sync_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r       <= ST_HUNT;
            zero_cnt_r    <= '0;
            bit_cnt_r     <= 5'd0;
            shift_r       <= 16'd0;
            word_addr_r   <= 16'd0;
            crc_r         <= 32'd0;
            crc_lo_r      <= 16'd0;
            crc_hi_sel_r  <= 1'b0;
            to_cnt_r      <= '0;
            data_out_r    <= 16'd0;
            address_r     <= '0;
            ready_r       <= 1'b0;
            length_r      <= 16'd0;
            frame_done_r  <= 1'b0;
            crc_ok_r      <= 1'b0;
            err_sync_r    <= 1'b0;
            err_len_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            zero_cnt_r    <= zero_cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            shift_r       <= shift_s;
            word_addr_r   <= word_addr_s;
            crc_r         <= crc_s;
            crc_lo_r      <= crc_lo_s;
            crc_hi_sel_r  <= crc_hi_sel_s;
            to_cnt_r      <= to_cnt_s;
            data_out_r    <= data_out_s;
            address_r     <= address_s;
            ready_r       <= ready_s;
            length_r      <= length_s;
            frame_done_r  <= frame_done_s;
            crc_ok_r      <= crc_ok_s;
            err_sync_r    <= err_sync_s;
            err_len_r     <= err_len_s;
            err_timeout_r <= err_timeout_s;
            busy_r        <= busy_s;
        end
    end

    // Next-state, datapath and output-pulse decode, acting only on bit events apart from the timeout.
    always_comb begin
        next_state_s  = state_r;
        zero_cnt_s    = zero_cnt_r;
        bit_cnt_s     = bit_cnt_r;
        shift_s       = shift_r;
        word_addr_s   = word_addr_r;
        crc_s         = crc_r;
        crc_lo_s      = crc_lo_r;
        crc_hi_sel_s  = crc_hi_sel_r;
        to_cnt_s      = to_cnt_r;
        data_out_s    = data_out_r;
        address_s     = address_r;
        ready_s       = 1'b0;
        length_s      = length_r;
        frame_done_s  = 1'b0;
        crc_ok_s      = crc_ok_r;
        err_sync_s    = 1'b0;
        err_len_s     = 1'b0;
        err_timeout_s = 1'b0;

        if (bit_ev_s) begin
            to_cnt_s  = '0;
            bit_cnt_s = (bit_cnt_r == 5'd16) ? 5'd0 : (bit_cnt_r + 5'd1);
            if (bit_cnt_r != 5'd16) begin
                shift_s = full_s;
            end else begin
                shift_s = shift_r;
            end

            case (state_r)
                ST_HUNT: begin
                    bit_cnt_s = 5'd0;
                    if (!bus.DATA_IN) begin
                        if (zero_cnt_r < ZC_W'(PREAMBLE_ZEROS)) begin
                            zero_cnt_s = zero_cnt_r + ZC_W'(1);
                        end else begin
                            zero_cnt_s = zero_cnt_r;
                        end
                    end else begin
                        if (zero_cnt_r >= ZC_W'(PREAMBLE_ZEROS)) begin
                            next_state_s = ST_LEN;
                            crc_s        = 32'hFFFF_FFFF;
                        end else begin
                            next_state_s = ST_HUNT;
                        end
                        zero_cnt_s = '0;
                    end
                end

                ST_LEN: begin
                    if (bit_cnt_r == 5'd16) begin
                        crc_hi_sel_s = 1'b0;
                        word_addr_s  = 16'd0;
                        if (!bus.DATA_IN) begin
                            err_sync_s   = 1'b1;
                            next_state_s = ST_HUNT;
                        end else begin
                            length_s = last_word_s;
                            if (last_word_s > 16'(MAX_PAYLOAD)) begin
                                err_len_s    = 1'b1;
                                next_state_s = ST_HUNT;
                            end else if (last_word_s == 16'd0) begin
                                next_state_s = ST_CRC;
                            end else begin
                                next_state_s = ST_PAY;
                            end
                        end
                    end else begin
                        next_state_s = ST_LEN;
                    end
                end

                ST_PAY: begin
                    if (bit_cnt_r == 5'd16) begin
                        if (!bus.DATA_IN) begin
                            err_sync_s   = 1'b1;
                            next_state_s = ST_HUNT;
                        end else begin
                            ready_s    = 1'b1;
                            data_out_s = last_word_s;
                            address_s  = word_addr_r[ADDR_W-1:0];
                            if ((word_addr_r + 16'd2) >= length_r) begin
                                next_state_s = ST_CRC;
                                crc_hi_sel_s = 1'b0;
                            end else begin
                                word_addr_s = word_addr_r + 16'd2;
                            end
                        end
                    end else if (((bit_cnt_r == 5'd7) || (bit_cnt_r == 5'd15)) && (byte_idx_s < length_r)) begin
                        // Odd-length padding byte never reaches this update.
                        crc_s = crc32_byte(crc_r, full_s[7:0]);
                    end else begin
                        crc_s = crc_r;
                    end
                end

                ST_CRC: begin
                    if (!crc_hi_sel_r) begin
                        if (bit_cnt_r == 5'd16) begin
                            if (!bus.DATA_IN) begin
                                err_sync_s   = 1'b1;
                                next_state_s = ST_HUNT;
                            end else begin
                                crc_lo_s     = last_word_s;
                                crc_hi_sel_s = 1'b1;
                            end
                        end else begin
                            crc_hi_sel_s = 1'b0;
                        end
                    end else if (bit_cnt_r == 5'd15) begin
                        frame_done_s = 1'b1;
                        crc_ok_s     = (CHECK_CRC != 0) ? ({end_word_s, crc_lo_r} == ~crc_r) : 1'b1;
                        next_state_s = ST_HUNT;
                    end else begin
                        crc_hi_sel_s = 1'b1;
                    end
                end

                default: begin
                    next_state_s = ST_HUNT;
                end
            endcase
        end else begin
            if (state_r != ST_HUNT) begin
                if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_timeout_s = 1'b1;
                    next_state_s  = ST_HUNT;
                    to_cnt_s      = '0;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_s = '0;
            end
        end

        busy_s = (next_state_s != ST_HUNT);
    end

    assign bus.DATA_OUT    = data_out_r;
    assign bus.ADDRESS     = address_r;
    assign bus.READY       = ready_r;
    assign bus.LENGTH      = length_r;
    assign bus.FRAME_DONE  = frame_done_r;
    assign bus.CRC_OK      = crc_ok_r;
    assign bus.ERR_SYNC    = err_sync_r;
    assign bus.ERR_LEN     = err_len_r;
    assign bus.ERR_TIMEOUT = err_timeout_r;
    assign bus.BUSY        = busy_r;

endmodule
